// File: rtl/nand_flash_target.sv
// Behavioural NAND flash target: command/address/data latch decoding, page register,
// read/program/erase with busy timing, status and ID readout.
module nand_flash_target #(
  parameter int PAGE_BYTES      = 16,
  parameter int NUM_PAGES       = 16,
  parameter int PAGES_PER_BLOCK = 4,
  parameter int READ_BUSY       = 4,
  parameter int PROG_BUSY       = 8,
  parameter int ERASE_BUSY      = 16,
  parameter logic [7:0] MAKER_ID  = 8'hEC,
  parameter logic [7:0] DEVICE_ID = 8'hDA
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flash_ce_n,
  input  logic       flash_cle,
  input  logic       flash_ale,
  input  logic       flash_we_n,
  input  logic       flash_re_n,
  input  logic       flash_wp_n,
  input  logic [7:0] flash_io_in,
  output logic [7:0] flash_io_out,
  output logic       flash_io_oe,
  output logic       flash_rb_n
);
  localparam int CW    = $clog2(PAGE_BYTES);
  localparam int RW    = $clog2(NUM_PAGES);
  localparam int BW    = $clog2(PAGES_PER_BLOCK);
  localparam int CNT_W = 16;

  typedef enum logic [2:0] {IDLE, ADDR, DATA_IN, BUSY, DATA_OUT, STATUS_OUT, ID_OUT} state_t;
  typedef enum logic [1:0] {OP_READ, OP_PROG, OP_ERASE, OP_ID} op_t;

  state_t state, busy_next;
  op_t    op;
  logic [PAGE_BYTES-1:0][7:0] mem [NUM_PAGES];
  logic [PAGE_BYTES-1:0][7:0] page_reg;
  logic [CW-1:0]    col, col_nxt;
  logic [RW-1:0]    row;
  logic [15:0]      col16;
  logic [23:0]      row24;
  logic [2:0]       acnt, need, apos;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       id_idx;
  logic             fail, stat_flag;
  logic             is_cmd, is_addr, is_data, rd_stb, can_start;
  logic [7:0]       out_byte;
  logic             src_ok;

  assign is_cmd    = !flash_ce_n && !flash_we_n &&  flash_cle && !flash_ale;
  assign is_addr   = !flash_ce_n && !flash_we_n && !flash_cle &&  flash_ale;
  assign is_data   = !flash_ce_n && !flash_we_n && !flash_cle && !flash_ale;
  assign rd_stb    = !flash_ce_n && !flash_re_n;
  assign can_start = state inside {IDLE, ADDR, DATA_OUT, STATUS_OUT, ID_OUT};
  assign col_nxt   = col + 1'b1;
  assign col16     = 16'(col);
  assign row24     = 24'(row);

  // Erase sequences carry row bytes only, so their first byte lands at position 2.
  always_comb begin
    case (op)
      OP_ERASE: need = 3'd3;
      OP_ID:    need = 3'd1;
      default:  need = 3'd5;
    endcase
    apos = (op == OP_ERASE) ? acnt + 3'd2 : acnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy_next <= IDLE;
      op        <= OP_READ;
      page_reg  <= '1;
      col       <= '0;
      row       <= '0;
      acnt      <= '0;
      cnt       <= '0;
      id_idx    <= '0;
      fail      <= 1'b0;
      stat_flag <= 1'b0;
      flash_rb_n <= 1'b1;
    end else begin
      if (state == BUSY) begin
        if (cnt == '0) begin
          state      <= busy_next;
          flash_rb_n <= 1'b1;
          stat_flag  <= 1'b0;
        end else
          cnt <= cnt - 1'b1;
      end

      if (is_addr && state == ADDR && acnt < need) begin
        acnt <= acnt + 1'b1;
        if (op != OP_ID)
          case (apos)
            3'd0: col <= CW'({col16[15:8], flash_io_in});
            3'd1: col <= CW'({flash_io_in, col16[7:0]});
            3'd2: row <= RW'({row24[23:8], flash_io_in});
            3'd3: row <= RW'({row24[23:16], flash_io_in, row24[7:0]});
            3'd4: row <= RW'({flash_io_in, row24[15:0]});
            default: ;
          endcase
        if (acnt == need - 3'd1) begin
          if (op == OP_PROG) state <= DATA_IN;
          else if (op == OP_ID) begin
            state  <= ID_OUT;
            id_idx <= '0;
          end
        end
      end

      if (is_data && state == DATA_IN) begin
        page_reg[col] <= flash_io_in;
        col           <= col_nxt;
      end

      if (rd_stb) begin
        if (state == DATA_OUT) col <= col_nxt;
        if (state == ID_OUT && id_idx != 2'd2) id_idx <= id_idx + 1'b1;
      end

      if (is_cmd) begin
        case (flash_io_in)
          8'h00, 8'h80, 8'h60, 8'h90:
            if (can_start) begin
              state <= ADDR;
              acnt  <= '0;
              case (flash_io_in)
                8'h00:   op <= OP_READ;
                8'h80: begin
                  op       <= OP_PROG;
                  page_reg <= '1;
                end
                8'h60:   op <= OP_ERASE;
                default: op <= OP_ID;
              endcase
            end
          8'h30:
            if (state == ADDR && op == OP_READ && acnt == need) begin
              page_reg   <= mem[row];
              state      <= BUSY;
              busy_next  <= DATA_OUT;
              cnt        <= CNT_W'(READ_BUSY - 1);
              flash_rb_n <= 1'b0;
              stat_flag  <= 1'b0;
            end
          8'h10:
            if (state == DATA_IN) begin
              if (flash_wp_n) mem[row] <= mem[row] & page_reg;
              fail       <= !flash_wp_n;
              state      <= BUSY;
              busy_next  <= STATUS_OUT;
              cnt        <= CNT_W'(PROG_BUSY - 1);
              flash_rb_n <= 1'b0;
              stat_flag  <= 1'b0;
            end
          8'hD0:
            if (state == ADDR && op == OP_ERASE && acnt == need) begin
              for (int p = 0; p < NUM_PAGES; p++)
                if (flash_wp_n && ((RW'(p) >> BW) == (row >> BW))) mem[p] <= '1;
              fail       <= !flash_wp_n;
              state      <= BUSY;
              busy_next  <= STATUS_OUT;
              cnt        <= CNT_W'(ERASE_BUSY - 1);
              flash_rb_n <= 1'b0;
              stat_flag  <= 1'b0;
            end
          // Status during busy is an overlay; the operation keeps counting underneath.
          8'h70:
            if (state == BUSY) stat_flag <= 1'b1;
            else               state     <= STATUS_OUT;
          8'hFF: begin
            state      <= IDLE;
            flash_rb_n <= 1'b1;
            stat_flag  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    out_byte = 8'h00;
    src_ok   = 1'b0;
    case (state)
      DATA_OUT: begin
        out_byte = page_reg[col];
        src_ok   = 1'b1;
      end
      STATUS_OUT: begin
        out_byte = {flash_wp_n, flash_rb_n, flash_rb_n, 4'b0, fail};
        src_ok   = 1'b1;
      end
      ID_OUT: begin
        out_byte = (id_idx == 2'd0) ? MAKER_ID : (id_idx == 2'd1) ? DEVICE_ID : 8'h00;
        src_ok   = 1'b1;
      end
      BUSY: begin
        out_byte = {flash_wp_n, flash_rb_n, flash_rb_n, 4'b0, fail};
        src_ok   = stat_flag;
      end
      default: ;
    endcase
    flash_io_oe  = rd_stb && src_ok && !rst;
    flash_io_out = flash_io_oe ? out_byte : 8'h00;
  end
endmodule

// File: tb/tb_nand_flash_target.sv
// Randomized scoreboard bench for nand_flash_target against a page-level array model.
module tb_nand_flash_target;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce_n = 1'b0, cle = 1'b0, ale = 1'b0, we_n = 1'b1, re_n = 1'b1, wp_n = 1'b1;
  logic [7:0] io_in = 8'h00;
  logic [7:0] io_out;
  logic       io_oe, rb_n;

  nand_flash_target dut (
    .clk(clk), .rst(rst), .flash_ce_n(ce_n), .flash_cle(cle), .flash_ale(ale),
    .flash_we_n(we_n), .flash_re_n(re_n), .flash_wp_n(wp_n), .flash_io_in(io_in),
    .flash_io_out(io_out), .flash_io_oe(io_oe), .flash_rb_n(rb_n)
  );

  always #5 clk = ~clk;

  int checks = 0, passes = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mem_m [16][16];
  logic [7:0] pbuf [32];
  logic       fail_m = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Every read strobe has a pushed expectation; compare it while the strobe is held.
  always @(negedge clk) begin
    if (!re_n) begin
      if (exp_q.size() == 0) chk("unexpected_strobe", 1, 0);
      else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("rd_oe", {31'b0, io_oe}, 1);
        chk("rd_data", {24'b0, io_out}, {24'b0, e});
      end
    end
  end

  task automatic wr(input logic c, input logic a, input logic [7:0] d);
    cle = c; ale = a; io_in = d; we_n = 1'b0;
    @(posedge clk); #1;
    we_n = 1'b1; cle = 1'b0; ale = 1'b0;
  endtask
  task automatic cmd(input logic [7:0] d); wr(1'b1, 1'b0, d); endtask
  task automatic adr(input logic [7:0] d); wr(1'b0, 1'b1, d); endtask
  task automatic exp_rd(input logic [7:0] e);
    exp_q.push_back(e);
    re_n = 1'b0;
    @(posedge clk); #1;
    re_n = 1'b1;
  endtask

  function automatic logic [7:0] hi_junk(input int v);
    return 8'(($urandom_range(0, 15) << 4) | v);
  endfunction

  task automatic wait_busy(input string nm, input int n);
    int c = 0;
    chk({nm, "_rb_low"}, {31'b0, rb_n}, 0);
    while (!rb_n && c < 200) begin @(posedge clk); #1; c++; end
    chk({nm, "_busy_len"}, c, n);
  endtask

  task automatic do_erase(input int blk, input logic wp);
    int pg;
    pg = blk * 4 + $urandom_range(0, 3);
    cmd(8'h60); adr(hi_junk(pg)); adr(8'($urandom)); adr(8'($urandom));
    wp_n = wp;
    cmd(8'hD0);
    if (wp) for (int p = blk * 4; p < blk * 4 + 4; p++) for (int b = 0; b < 16; b++) mem_m[p][b] = 8'hFF;
    fail_m = !wp;
    wait_busy("erase", 16);
  endtask

  task automatic do_prog(input int pg, input int col, input int n, input logic wp);
    logic [7:0] preg [16];
    for (int b = 0; b < 16; b++) preg[b] = 8'hFF;
    cmd(8'h80); adr(hi_junk(col)); adr(8'($urandom)); adr(hi_junk(pg)); adr(8'($urandom)); adr(8'($urandom));
    for (int i = 0; i < n; i++) begin
      wr(1'b0, 1'b0, pbuf[i]);
      preg[(col + i) % 16] = pbuf[i];
    end
    wp_n = wp;
    cmd(8'h10);
    if (wp) for (int b = 0; b < 16; b++) mem_m[pg][b] = mem_m[pg][b] & preg[b];
    fail_m = !wp;
  endtask

  task automatic do_read(input int pg, input int col, input int n);
    wp_n = 1'b1;
    cmd(8'h00); adr(hi_junk(col)); adr(8'($urandom)); adr(hi_junk(pg)); adr(8'($urandom)); adr(8'($urandom));
    cmd(8'h30);
    wait_busy("read", 4);
    for (int i = 0; i < n; i++) exp_rd(mem_m[pg][(col + i) % 16]);
  endtask

  task automatic do_status();
    cmd(8'h70);
    exp_rd({wp_n, 1'b1, 1'b1, 4'b0, fail_m});
  endtask

  task automatic do_id();
    cmd(8'h90); adr(8'($urandom));
    exp_rd(8'hEC); exp_rd(8'hDA); exp_rd(8'h00); exp_rd(8'h00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_rb_n", {31'b0, rb_n}, 1);
    chk("reset_oe", {31'b0, io_oe}, 0);
    chk("reset_io_out", {24'b0, io_out}, 0);

    for (int b = 0; b < 4; b++) do_erase(b, 1'b1);

    // Erase block 0, read page 2, status E0.
    do_erase(0, 1'b1);
    do_read(2, 0, 16);
    do_status();

    // Program page 1 with 00..0F, read 20 bytes from col 4 (wraps).
    for (int i = 0; i < 16; i++) pbuf[i] = 8'(i);
    do_prog(1, 0, 16, 1'b1);
    wait_busy("prog", 8);
    do_read(1, 4, 20);

    // Program-over-program ANDs the data.
    for (int i = 0; i < 16; i++) pbuf[i] = 8'hF0;
    do_prog(6, 0, 16, 1'b1); wait_busy("prog", 8);
    for (int i = 0; i < 16; i++) pbuf[i] = 8'h3C;
    do_prog(6, 0, 16, 1'b1); wait_busy("prog", 8);
    do_read(6, 0, 16);

    // Write-protected program: status 61, page untouched.
    do_erase(2, 1'b1);
    for (int i = 0; i < 16; i++) pbuf[i] = 8'($urandom);
    do_prog(9, 3, 16, 1'b0); wait_busy("prog_wp", 8);
    do_status();
    do_read(9, 0, 16);

    // Status during erase busy, then ID readout.
    cmd(8'h60); adr(8'h00); adr(8'h00); adr(8'h00);
    cmd(8'hD0);
    for (int p = 0; p < 4; p++) for (int b = 0; b < 16; b++) mem_m[p][b] = 8'hFF;
    fail_m = 1'b0;
    cmd(8'h70);
    exp_rd(8'h80);
    c = 0;
    while (!rb_n && c < 200) begin @(posedge clk); #1; c++; end
    chk("erase_busy_remaining", c, 14);
    do_id();

    // Abort a program on its third busy cycle; committed data survives.
    for (int i = 0; i < 16; i++) pbuf[i] = 8'($urandom);
    do_prog(5, 0, 16, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    chk("abort_still_busy", {31'b0, rb_n}, 0);
    cmd(8'hFF);
    chk("abort_rb_n", {31'b0, rb_n}, 1);
    do_read(5, 0, 16);

    // Reset during erase busy: count abandoned, erase kept, fail cleared.
    do_erase(1, 1'b1);
    cmd(8'h60); adr(8'h0C); adr(8'h00); adr(8'h00); cmd(8'hD0);
    for (int p = 12; p < 16; p++) for (int b = 0; b < 16; b++) mem_m[p][b] = 8'hFF;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    fail_m = 1'b0;
    chk("rst_busy_rb_n", {31'b0, rb_n}, 1);
    chk("rst_busy_oe", {31'b0, io_oe}, 0);
    do_status();
    do_read(13, 7, 16);

    // Randomized mix.
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 4))
        0: begin
          do_erase($urandom_range(0, 3), ($urandom_range(0, 4) != 0));
          do_status(); wp_n = 1'b1;
        end
        1: begin
          int n;
          n = $urandom_range(1, 20);
          for (int i = 0; i < n; i++) pbuf[i] = 8'($urandom);
          do_prog($urandom_range(0, 15), $urandom_range(0, 15), n, ($urandom_range(0, 4) != 0));
          wait_busy("rprog", 8);
          do_status(); wp_n = 1'b1;
        end
        2: do_read($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(1, 40));
        3: do_status();
        default: do_id();
      endcase
    end

    repeat (2) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/nand_flash_target.md
NAND_FLASH_TARGET -- requirements
Module: nand_flash_target

Interface
REQ-001 SHALL have parameter PAGE_BYTES, default 16, bytes per page (power of two).
REQ-002 SHALL have parameter NUM_PAGES, default 16, total pages in the array (power of two).
REQ-003 SHALL have parameter PAGES_PER_BLOCK, default 4, pages per erase block (power of two).
REQ-004 SHALL have parameters READ_BUSY, PROG_BUSY, ERASE_BUSY, defaults 4, 8, 16, busy cycle counts (each >= 1).
REQ-005 SHALL have parameters MAKER_ID and DEVICE_ID, defaults 8'hEC and 8'hDA, which are the read-ID bytes.
REQ-006 SHALL have one clock and a synchronous, active-high reset, with the ports listed below.
REQ-007 clk  input  1  clock; all state changes on rising edge.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 flash_ce_n  input  1  chip enable, active low; while high, all strobes are ignored and state is held.
REQ-010 flash_cle, flash_ale  input  1 each  command and address latch enables.
REQ-011 flash_we_n  input  1  write strobe; a byte is latched on every clk edge where ce_n=0 and we_n=0.
REQ-012 flash_re_n  input  1  read strobe; a byte is consumed on every clk edge where ce_n=0 and re_n=0.
REQ-013 flash_wp_n  input  1  write protect, active low.
REQ-014 flash_io_in  input  8  byte from the controller.
REQ-015 flash_io_out / flash_io_oe  output  8 / 1  byte to the controller and its drive enable.
REQ-016 flash_rb_n  output  1  ready/busy, low while busy.

Function
REQ-017 Latched byte classification: CLE=1 and ALE=0 is a command; ALE=1 and CLE=0 is an address; both 0 is data; both 1 is ignored.
REQ-018 States: IDLE, ADDR, DATA_IN, BUSY, DATA_OUT, STATUS_OUT, ID_OUT.
REQ-019 Commands 00, 80 and 60 SHALL be accepted in IDLE, DATA_OUT, STATUS_OUT or ID_OUT, and in ADDR as a restart. Each enters ADDR expecting 5, 5 and 3 address bytes respectively.
REQ-020 Address order for 5-byte sequences: col[7:0], col[15:8], row[7:0], row[15:8], row[23:16]; 3-byte sequences carry row bytes only. Column is used modulo PAGE_BYTES and row modulo NUM_PAGES. Surplus address bytes are ignored.
REQ-021 Command 30 after a complete 00 address SHALL copy page[row] into the page register, set the column pointer, and enter BUSY for READ_BUSY cycles, then DATA_OUT.
REQ-022 Command 80 SHALL preset the page register to all 8'hFF. After the 5 address bytes the block enters DATA_IN; each data byte writes page_reg[col], then col = (col+1) mod PAGE_BYTES.
REQ-023 Command 10 in DATA_IN with wp_n=1 SHALL set page[row] = page[row] AND page_reg, fail=0, then BUSY for PROG_BUSY cycles.
REQ-024 Command D0 after a complete 60 address with wp_n=1 SHALL set every page of block row/PAGES_PER_BLOCK to 8'hFF, fail=0, then BUSY for ERASE_BUSY cycles.
REQ-025 If wp_n=0 at 10 or D0, the array SHALL be unchanged, fail=1, and BUSY still runs for the full count.
REQ-026 After a program or erase completes, BUSY SHALL exit to STATUS_OUT.
REQ-027 flash_rb_n SHALL go low on the edge that latches 30, 10 or D0, stay low exactly N cycles, and return high as the state leaves BUSY.
REQ-028 In DATA_OUT, flash_io_oe=1 and flash_io_out=page_reg[col] combinationally whenever ce_n=0 and re_n=0; each read strobe advances col modulo PAGE_BYTES, so reads wrap.
REQ-029 Command 70 is accepted in any state, including BUSY. The next read strobes return the status byte {wp_n, rdy, rdy, 4'b0, fail}, where rdy=rb_n. After BUSY, the saved state is resumed.
REQ-030 Command 90 followed by one address byte SHALL enter ID_OUT. Read strobes return MAKER_ID, then DEVICE_ID, then 8'h00 repeatedly.
REQ-031 Command FF is accepted in any state. It SHALL abort to IDLE and set rb_n=1 on the next cycle. Array updates already committed are kept.
REQ-032 Unknown or out-of-sequence commands, and data bytes outside DATA_IN, SHALL be ignored with no state change.
REQ-033 flash_io_oe SHALL be 0 whenever re_n=1 or ce_n=1.

Reset
REQ-034 On rst: state=IDLE, flash_rb_n=1, flash_io_oe=0, flash_io_out=8'h00, fail=0, col=0, row=0, page register=8'hFF.
REQ-035 Array contents SHALL be unaffected by rst.
REQ-036 A reset during BUSY SHALL abandon the busy count, and rb_n SHALL be 1 on the next cycle.

Verification
REQ-037 Erase of block 0 (60, 00, 00, 00, D0) then read of page 2 (00, 5 address bytes, 30) -> rb_n low for 16 cycles; 16 reads return 8'hFF; status read returns 8'hE0.
REQ-038 Program of page 1 with bytes 00..0F, then read of page 1 from col 4 with 20 strobes -> returns 04..0F, 00..07.
REQ-039 Page programmed with 8'hF0 then programmed again with 8'h3C -> readback 8'h30.
REQ-040 wp_n=0 during a program of an erased page -> status 8'h61; readback all 8'hFF.
REQ-041 Command 70 issued during erase BUSY -> reads return 8'h80; 90, 00 then 3 reads -> EC, DA, 00.
REQ-042 FF on the third cycle of a program BUSY -> rb_n=1 on the next cycle, state IDLE; programmed data is present.
